// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit a +/- b +/- cin, CHUNK bits per clock,
// with a registered inter-chunk carry and a start/busy/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHK = WIDTH / CHUNK;
  localparam int IDXW = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, shadow, shadow_nxt;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             accept, last;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chk, b_chk, chk_sum;
  logic             chk_cout, chk_cmsb;

  // NOTE: every variable written in an always_comb gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == IDXW'(NCHK - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One chunk slice of the ripple; the carry into the chunk MSB falls out of
  // the sum bit, which covers CHUNK == 1 without a special case.
  always_comb begin
    base                  = 32'(idx) * 32'(CHUNK);
    a_chk                 = CHUNK'(a_r >> base);
    b_chk                 = CHUNK'(b_r >> base);
    {chk_cout, chk_sum}   = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry};
    chk_cmsb              = chk_sum[CHUNK-1] ^ a_chk[CHUNK-1] ^ b_chk[CHUNK-1];
    shadow_nxt            = (shadow & ~(CMASK << base)) | (WIDTH'(chk_sum) << base);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        // Subtraction is a + ~b + ~cin, so invert b and flip the carry-in once here.
        a_r   <= a;
        b_r   <= b ^ {WIDTH{sub}};
        carry <= cin ^ sub;
        idx   <= '0;
      end else if (state == RUN) begin
        shadow <= shadow_nxt;
        carry  <= chk_cout;
        idx    <= last ? '0 : idx + 1'b1;
      end
      if (last) begin
        sum  <= shadow_nxt;
        cout <= chk_cout;
        ovf  <= chk_cmsb ^ chk_cout;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed handshake/reset cases on an
// 8/2 instance plus randomised checks of 8/2, 8/1, 8/8 and 32/4 against an arithmetic model.
module tb_seq_chunk_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic        s_start, s_cin, s_sub;
  logic [31:0] s_a, s_b;
  logic        bz1, d1, c1, v1, bz8, d8, c8, v8, bz32, d32, c32, v32;
  logic [7:0]  r1, r8;
  logic [31:0] r32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin),
    .sub(s_sub), .busy(bz1), .done(d1), .sum(r1), .cout(c1), .ovf(v1)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin),
    .sub(s_sub), .busy(bz8), .done(d8), .sum(r8), .cout(c8), .ovf(v8)
  );

  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_w32 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
    .sub(s_sub), .busy(bz32), .done(d32), .sum(r32), .cout(c32), .ovf(v32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Integer-arithmetic reference: returns {ovf, cout, sum[31:0]} for a w-bit operation.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                                          input logic tc, input logic ts);
    longint modv, half, ua, ub, sa, sb, ci, r, sr;
    logic   c, v;
    modv = longint'(1) << w;
    half = modv >> 1;
    ua   = longint'(ta) & (modv - 1);
    ub   = longint'(tb_) & (modv - 1);
    sa   = (ua >= half) ? ua - modv : ua;
    sb   = (ub >= half) ? ub - modv : ub;
    ci   = tc ? 1 : 0;
    if (!ts) begin
      r  = ua + ub + ci;
      c  = (r >= modv);
      sr = sa + sb + ci;
    end else begin
      r  = ua - ub - ci;
      c  = (r >= 0);
      sr = sa - sb - ci;
    end
    v = (sr >= half) || (sr < -half);
    return {v, c, 32'(r & (modv - 1))};
  endfunction

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done; counts busy cycles and watches the held result.
  task automatic wait_done(output int nbusy, output bit found, output bit stable);
    logic [9:0] held;
    held   = {ovf, cout, sum};
    nbusy  = 0;
    found  = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin
        if (busy) nbusy++;
        if ({ovf, cout, sum} !== held) stable = 1'b0;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic ts, input logic [9:0] exp);
    int nb; bit f, st;
    launch(ta, tb_, tc, ts);
    wait_done(nb, f, st);
    check({tag, "_done_seen"}, 64'(f), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd4);
    check({tag, "_held_stable"}, 64'(st), 64'd1);
    check({tag, "_result"}, 64'({ovf, cout, sum}), 64'(exp));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_drops"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nb, n_done, l1, l8, l32;
    bit f, st;
    logic [33:0] e, e8;
    logic [9:0]  g1, g8;
    logic [33:0] g32;
    logic [7:0]  ra, rb;
    logic        rc, rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, ovf, cout, sum}), 64'd0);

    do_op("add_basic", 8'h37, 8'h05, 1'b0, 1'b0, 10'h03C);
    do_op("add_wrap", 8'hFF, 8'h00, 1'b1, 1'b0, 10'h100);
    do_op("add_sovf", 8'h70, 8'h10, 1'b0, 1'b0, 10'h280);
    do_op("sub_basic", 8'h30, 8'h06, 1'b0, 1'b1, 10'h12A);
    do_op("sub_borrow", 8'h05, 8'h06, 1'b0, 1'b1, 10'h0FF);

    // start pulsed with different operands while busy must be ignored
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, f, st);
    check("busy_start_done_seen", 64'(f), 64'd1);
    check("busy_start_result", 64'({ovf, cout, sum}), 64'h046);
    @(negedge clk);
    check("busy_start_no_second_done", 64'({done, busy}), 64'd0);

    // start raised in the done cycle is accepted
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(nb, f, st);
    check("b2b_first_result", 64'({f, ovf, cout, sum}), 64'h430);
    launch(8'h40, 8'h40, 1'b0, 1'b0);
    check("b2b_done_one_cycle", 64'(done), 64'd0);
    check("b2b_accepted_busy", 64'(busy), 64'd1);
    wait_done(nb, f, st);
    check("b2b_second_done_seen", 64'(f), 64'd1);
    check("b2b_second_latency", 64'(nb), 64'd4);
    check("b2b_second_result", 64'({ovf, cout, sum}), 64'h280);
    @(negedge clk);

    // asynchronous reset two RUN edges into an operation
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_outputs", 64'({busy, done, ovf, cout, sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    do_op("post_reset", 8'h37, 8'h05, 1'b0, 1'b0, 10'h03C);

    for (int n = 0; n < 25; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      e = ref_add(8, {24'd0, ra}, {24'd0, rb}, rc, rs);
      do_op("rand_w8c2", ra, rb, rc, rs, {e[33:32], e[7:0]});
    end

    for (int n = 0; n < 20; n++) begin
      s_a = $urandom; s_b = $urandom;
      s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
      if (n == 0) begin s_a = 32'h7FFF_FFFF; s_b = 32'h0000_0001; s_cin = 1'b0; s_sub = 1'b0; end
      e8 = ref_add(8, s_a, s_b, s_cin, s_sub);
      e  = ref_add(32, s_a, s_b, s_cin, s_sub);
      s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;
      l1 = 0; l8 = 0; l32 = 0; g1 = '0; g8 = '0; g32 = '0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (d1 && l1 == 0)   begin l1 = c;  g1 = {v1, c1, r1}; end
        if (d8 && l8 == 0)   begin l8 = c;  g8 = {v8, c8, r8}; end
        if (d32 && l32 == 0) begin l32 = c; g32 = {v32, c32, r32}; end
      end
      check("sweep_w8c1_latency", 64'(l1), 64'd9);
      check("sweep_w8c1_result", 64'(g1), 64'({e8[33:32], e8[7:0]}));
      check("sweep_w8c8_latency", 64'(l8), 64'd2);
      check("sweep_w8c8_result", 64'(g8), 64'({e8[33:32], e8[7:0]}));
      check("sweep_w32c4_latency", 64'(l32), 64'd9);
      check("sweep_w32c4_result", 64'(g32), 64'(e));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
